// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, byte-enable encodings and alignment helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Anything that is not a byte or half enable is handled as a full word.
    function automatic logic [3:0] norm_be(input logic [3:0] byte_en);
        return byte_en == BE_BYTE ? BE_BYTE : byte_en == BE_HALF ? BE_HALF : BE_WORD;
    endfunction

    function automatic logic is_aligned(input logic [3:0] byte_en, input logic [1:0] off);
        return byte_en == BE_BYTE ? 1'b1 : byte_en == BE_HALF ? ~off[0] : off == 2'b00;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/grant/response data-memory port between the LSU and data memory.
interface lsu_ctrl_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/lsu_ctrl_load_extend.sv
// load_extend: lane-shifts a raw memory word and sign/zero-extends it to the access size.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] dm_rdata_i,
    input  logic [1:0]  off_i,
    input  logic [3:0]  byte_en_i,
    input  logic        us_i,
    output logic [31:0] data_o
);
    logic [31:0] w;

    assign w = dm_rdata_i >> {off_i, 3'b000};
    assign data_o = byte_en_i == BE_BYTE ? {{24{~us_i & w[7]}}, w[7:0]} :
                    byte_en_i == BE_HALF ? {{16{~us_i & w[15]}}, w[15:0]} : w;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store sequencer driving a request/grant/response memory port,
// stalling the pipeline while an access is in flight and flagging misalignment and timeouts.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        us_i,
    input  logic [3:0]  byte_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    lsu_ctrl_if.master  dm
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    lsu_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic        we_q, us_q, rv_q, err_q, mis_q;
    logic [31:0] addr_q, wdata_q, rdata_q, ld_data;
    logic [3:0]  dm_be_q, be_q;
    logic [1:0]  off_q;
    logic        access, aligned, start, busy, timeout, tmo_evt;
    logic [3:0]  be_n;
    logic [1:0]  off;

    assign off     = addr_i[1:0];
    assign be_n    = norm_be(byte_en_i);
    assign access  = mem_valid_i & (mem_read_i | mem_write_i);
    assign aligned = is_aligned(be_n, off);
    // Gating with rst_n keeps stall low while reset is held, like every registered output.
    assign start   = rst_n & (state_q == IDLE) & access & aligned;
    assign busy    = (state_q == REQ) | (state_q == WAIT);
    assign timeout = int'(cnt_q) >= MAX_WAIT - 1;
    assign tmo_evt = timeout & (((state_q == REQ) & ~dm.dm_gnt) | ((state_q == WAIT) & ~dm.dm_rvalid));

    load_extend u_ext (
        .dm_rdata_i (dm.dm_rdata),
        .off_i      (off_q),
        .byte_en_i  (be_q),
        .us_i       (us_q),
        .data_o     (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? REQ : IDLE;
            REQ:     state_d = dm.dm_gnt ? (we_q ? DONE : WAIT) : timeout ? DONE : REQ;
            WAIT:    state_d = (dm.dm_rvalid | timeout) ? DONE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o   = start | busy;
        dm.dm_req = state_q == REQ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dm_be_q <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            be_q    <= '0;
            us_q    <= 1'b0;
            rdata_q <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            // Counter saturates at the timeout point so a last-cycle grant still sees an expired budget in WAIT.
            cnt_q <= busy ? (timeout ? cnt_q : cnt_q + 1'b1) : '0;
            if (start) begin
                we_q    <= mem_write_i;
                addr_q  <= {addr_i[31:2], 2'b00};
                dm_be_q <= be_n << off;
                wdata_q <= wdata_i << {off, 3'b000};
                off_q   <= off;
                be_q    <= be_n;
                us_q    <= us_i;
            end
            if (tmo_evt) rdata_q <= '0;
            else if ((state_q == WAIT) & dm.dm_rvalid) rdata_q <= ld_data;
            rv_q  <= (state_q == WAIT) & dm.dm_rvalid;
            err_q <= tmo_evt;
            mis_q <= (state_q == IDLE) & access & ~aligned;
        end
    end

    assign dm.dm_we       = we_q;
    assign dm.dm_addr     = addr_q;
    assign dm.dm_be       = dm_be_q;
    assign dm.dm_wdata    = wdata_q;
    assign rdata_o        = rdata_q;
    assign rdata_valid_o  = rv_q;
    assign bus_err_o      = err_q;
    assign misaligned_o   = mis_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven and randomized checks of lsu_ctrl against a transaction-level model.
module tb_lsu_ctrl;
    localparam int MW = 8;

    typedef struct {
        logic        valid, rd, wr, us;
        logic [3:0]  be;
        logic [31:0] addr, wdata, mem;
        int          g, r;
        logic        sticky, early;
        logic        e_mis, e_err;
        int          e_n;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rdata;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, us = 1'b0;
    logic [3:0]  byte_en = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, rdata_valid, misaligned, bus_err;
    logic [31:0] rdata;
    int          total = 0, passed = 0;
    vec_t        tbl[15];

    lsu_ctrl_if dm();

    lsu_ctrl #(.MAX_WAIT(MW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid_i   (mem_valid),
        .mem_read_i    (mem_read),
        .mem_write_i   (mem_write),
        .us_i          (us),
        .byte_en_i     (byte_en),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .stall_o       (stall),
        .rdata_o       (rdata),
        .rdata_valid_o (rdata_valid),
        .misaligned_o  (misaligned),
        .bus_err_o     (bus_err),
        .dm            (dm)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic vec_t vin(input logic valid, rd, wr, u, input logic [3:0] be,
                                 input logic [31:0] a, wd, mem, input int g, r,
                                 input logic sticky, early);
        vec_t v;
        v = '{default: '0};
        v.valid = valid; v.rd = rd; v.wr = wr; v.us = u; v.be = be;
        v.addr = a; v.wdata = wd; v.mem = mem; v.g = g; v.r = r;
        v.sticky = sticky; v.early = early;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t v, input logic mis, err, input int n,
                                input logic [31:0] ea, input logic [3:0] eb,
                                input logic [31:0] ew, er);
        v.e_mis = mis; v.e_err = err; v.e_n = n;
        v.e_addr = ea; v.e_be = eb; v.e_wdata = ew; v.e_rdata = er;
        return v;
    endfunction

    // Reference: sizes in bytes, lane offset arithmetic and a cycle budget for the whole access.
    function automatic vec_t model(input vec_t v);
        int sz, off, bits, dl, rvi;
        logic acc;
        logic [63:0] w, mask;
        off = int'(v.addr[1:0]);
        sz = v.be == 4'd1 ? 1 : v.be == 4'd3 ? 2 : 4;
        acc = v.valid && (v.rd || v.wr);
        v.e_mis = acc && (off % sz != 0);
        v.e_err = 1'b0;
        v.e_n = 0;
        v.e_addr = v.addr & 32'hFFFF_FFFC;
        v.e_be = 4'(((1 << sz) - 1) << off);
        v.e_wdata = v.wdata << (8 * off);
        bits = 8 * sz;
        mask = (64'd1 << bits) - 1;
        w = {32'd0, v.mem} >> (8 * off);
        w = w & mask;
        if (!v.us && w[bits-1]) w = w | ~mask;
        v.e_rdata = w[31:0];
        if (acc && !v.e_mis) begin
            if (v.g >= MW) begin
                v.e_n = MW; v.e_err = 1'b1;
            end else if (v.wr) begin
                v.e_n = v.g + 1;
            end else begin
                dl = (MW - 1 > v.g + 1) ? MW - 1 : v.g + 1;
                rvi = v.g + 1 + v.r;
                if (rvi <= dl) v.e_n = rvi + 1;
                else begin v.e_n = dl + 1; v.e_err = 1'b1; end
            end
        end
        if (v.e_err) v.e_rdata = '0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic acc, rd_eff;
        int rq;
        acc = v.valid && (v.rd || v.wr);
        rd_eff = v.rd && !v.wr;
        rq = (v.g < MW) ? v.g + 1 : MW;
        @(posedge clk); #1;
        mem_valid = v.valid; mem_read = v.rd; mem_write = v.wr; us = v.us;
        byte_en = v.be; addr = v.addr; wdata = v.wdata;
        dm.dm_gnt = 1'b0; dm.dm_rvalid = 1'b0; dm.dm_rdata = v.mem;
        @(negedge clk);
        chk($sformatf("%s idle_stall", tag), stall, acc && !v.e_mis);
        chk($sformatf("%s idle_pulses", tag), {rdata_valid, bus_err, misaligned, dm.dm_req}, 4'b0);
        if (v.e_n == 0) begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("%s misaligned", tag), misaligned, v.e_mis);
            chk($sformatf("%s no_req", tag), {stall, dm.dm_req}, 2'b0);
            return;
        end
        for (int k = 0; k < v.e_n; k++) begin
            @(posedge clk); #1;
            dm.dm_gnt = (k == v.g) || (v.sticky && k > v.g);
            dm.dm_rvalid = (k == v.g + 1 + v.r) || (v.early && k == 0 && v.g > 0);
            @(negedge clk);
            chk($sformatf("%s c%0d stall", tag, k), stall, 1'b1);
            chk($sformatf("%s c%0d req", tag, k), dm.dm_req, k < rq);
            if (k < rq)
                chk($sformatf("%s c%0d fields", tag, k),
                    {dm.dm_we, dm.dm_addr, dm.dm_be, dm.dm_wdata},
                    {v.wr, v.e_addr, v.e_be, v.e_wdata});
        end
        @(posedge clk); #1;
        dm.dm_gnt = 1'b0; dm.dm_rvalid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("%s done_stall_req", tag), {stall, dm.dm_req}, 2'b0);
        chk($sformatf("%s done_valid_err", tag), {rdata_valid, bus_err}, {rd_eff && !v.e_err, v.e_err});
        if (rd_eff) chk($sformatf("%s rdata", tag), rdata, v.e_rdata);
    endtask

    initial begin
        dm.dm_gnt = 1'b0; dm.dm_rvalid = 1'b0; dm.dm_rdata = '0;
        #1;
        chk("reset outs", {stall, rdata_valid, misaligned, bus_err, dm.dm_req, dm.dm_we}, 6'b0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset bus", {dm.dm_addr, dm.dm_be, dm.dm_wdata}, 68'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        tbl[0]  = ex(vin(1,1,0,0,4'b0001,32'h1003,32'h0,32'h80FF_0000,0,0,0,0), 0,0,2,32'h1000,4'b1000,32'h0,32'hFFFF_FF80);
        tbl[1]  = ex(vin(1,1,0,1,4'b0011,32'h2002,32'h0,32'h8001_1234,0,0,0,0), 0,0,2,32'h2000,4'b1100,32'h0,32'h0000_8001);
        tbl[2]  = ex(vin(1,0,1,0,4'b0011,32'h0006,32'h0000_ABCD,32'h0,4,0,0,0), 0,0,5,32'h0004,4'b1100,32'hABCD_0000,32'h0);
        tbl[3]  = ex(vin(1,0,1,0,4'b1111,32'h0002,32'h1122_3344,32'h0,0,0,0,0), 1,0,0,32'h0,4'b0,32'h0,32'h0);
        tbl[4]  = ex(vin(1,1,0,0,4'b1111,32'h0100,32'h0,32'hDEAD_BEEF,99,0,0,0), 0,1,8,32'h0100,4'b1111,32'h0,32'h0);
        tbl[5]  = ex(vin(1,0,0,0,4'b1111,32'h0003,32'h0,32'h0,0,0,0,0), 0,0,0,32'h0,4'b0,32'h0,32'h0);
        tbl[6]  = ex(vin(0,1,0,0,4'b0011,32'h0001,32'h0,32'h0,0,0,0,0), 0,0,0,32'h0,4'b0,32'h0,32'h0);
        tbl[7]  = ex(vin(1,1,0,0,4'b1111,32'h0010,32'h0,32'h89AB_CDEF,2,3,1,1), 0,0,7,32'h0010,4'b1111,32'h0,32'h89AB_CDEF);
        tbl[8]  = ex(vin(1,1,1,0,4'b1111,32'h0008,32'h1234_5678,32'h0,0,0,0,0), 0,0,1,32'h0008,4'b1111,32'h1234_5678,32'h0);
        tbl[9]  = ex(vin(1,1,0,0,4'b0011,32'h0005,32'h0,32'h0,0,0,0,0), 1,0,0,32'h0,4'b0,32'h0,32'h0);
        tbl[10] = ex(vin(1,1,0,1,4'b0101,32'h0004,32'h0,32'hF000_000F,0,0,0,0), 0,0,2,32'h0004,4'b1111,32'h0,32'hF000_000F);
        tbl[11] = ex(vin(1,0,1,0,4'b1111,32'h0010,32'hCAFE_F00D,32'h0,7,0,0,0), 0,0,8,32'h0010,4'b1111,32'hCAFE_F00D,32'h0);
        tbl[12] = ex(vin(1,1,0,0,4'b1111,32'h0020,32'h0,32'h0000_0055,1,99,0,0), 0,1,8,32'h0020,4'b1111,32'h0,32'h0);
        tbl[13] = ex(vin(1,1,0,1,4'b0001,32'h0001,32'h0,32'h0000_8000,0,0,0,0), 0,0,2,32'h0000,4'b0010,32'h0,32'h0000_0080);
        tbl[14] = ex(vin(1,1,0,0,4'b0011,32'h0002,32'h0,32'h1234_5678,7,0,0,0), 0,0,9,32'h0000,4'b1100,32'h0,32'h0000_1234);
        for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Reset while the load waits for its data; a late rvalid must be ignored.
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; byte_en = 4'b1111; addr = 32'h40;
        dm.dm_rdata = 32'h7777_7777;
        @(posedge clk); #1 dm.dm_gnt = 1'b1;
        @(posedge clk); #1 dm.dm_gnt = 1'b0;
        @(negedge clk);
        chk("rst_seq wait_stall", {stall, dm.dm_req}, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_seq outs", {stall, rdata_valid, misaligned, bus_err, dm.dm_req, dm.dm_we}, 6'b0);
        chk("rst_seq bus", {dm.dm_addr, dm.dm_be, dm.dm_wdata, rdata}, 100'h0);
        mem_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; dm.dm_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_seq late_rvalid%0d", i), {rdata_valid, stall, dm.dm_req, bus_err}, 4'b0);
            @(posedge clk); #1;
        end
        dm.dm_rvalid = 1'b0;

        for (int i = 0; i < 200; i++) begin
            vec_t v;
            logic [31:0] a;
            int pick;
            logic [3:0] be;
            pick = $urandom_range(0, 3);
            be = pick == 0 ? 4'b0001 : pick == 1 ? 4'b0011 : pick == 2 ? 4'b1111 : 4'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            v = vin($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 1'($urandom), be,
                    a, $urandom, $urandom, $urandom_range(0, 9), $urandom_range(0, 8),
                    1'($urandom), 1'($urandom));
            run_vec(model(v), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
